// File: rtl/ysyx_22041207_mem_pkg.sv
// rtl/ysyx_22041207_mem_pkg.sv - shared types and default widths for the IFU/LSU memory arbiter
package ysyx_22041207_mem_pkg;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

endpackage

// File: rtl/ysyx_22041207_rr_arb2.sv
// rtl/ysyx_22041207_rr_arb2.sv - two-way round-robin picker with internal last-grant state
module ysyx_22041207_rr_arb2
    import ysyx_22041207_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       if_valid,
    input  logic       ls_valid,
    output logic [1:0] grant
);

    owner_t last_grant;

    // grant[0] = IFU, grant[1] = LSU; on a tie the side not served last wins
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (if_valid && ls_valid) begin
                grant = (last_grant == OWN_LS) ? 2'b01 : 2'b10;
            end else begin
                grant = {ls_valid, if_valid};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= OWN_LS;
        end else if (grant[1]) begin
            last_grant <= OWN_LS;
        end else if (grant[0]) begin
            last_grant <= OWN_IF;
        end
    end

endmodule

// File: rtl/ysyx_22041207_mem_arbiter.sv
// rtl/ysyx_22041207_mem_arbiter.sv - single-outstanding IFU/LSU arbiter onto one memory port
module ysyx_22041207_mem_arbiter
    import ysyx_22041207_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_resp_data,
    input  logic                ls_req_valid,
    input  logic [ADDR_W-1:0]   ls_req_addr,
    input  logic                ls_req_wen,
    input  logic [DATA_W-1:0]   ls_req_wdata,
    input  logic [DATA_W/8-1:0] ls_req_wmask,
    output logic                ls_req_ready,
    output logic                ls_resp_valid,
    output logic [DATA_W-1:0]   ls_resp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data
);

    state_t              state_q;
    state_t              state_n;
    owner_t              owner_q;
    logic [1:0]          grant;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wmask_q;
    logic [DATA_W-1:0]   resp_q;

    ysyx_22041207_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q == IDLE),
        .if_valid (if_req_valid),
        .ls_valid (ls_req_valid),
        .grant    (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // A response arriving outside WAIT is deliberately dropped
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (|grant) state_n = REQ;
            REQ:     if (mem_req_ready) state_n = WAIT;
            WAIT:    if (mem_resp_valid) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_IF;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            resp_q  <= '0;
        end else begin
            if (grant[1]) begin
                owner_q <= OWN_LS;
                addr_q  <= ls_req_addr;
                wen_q   <= ls_req_wen;
                wdata_q <= ls_req_wdata;
                wmask_q <= ls_req_wmask;
            end else if (grant[0]) begin
                owner_q <= OWN_IF;
                addr_q  <= if_req_addr;
                wen_q   <= 1'b0;
                wdata_q <= '0;
                wmask_q <= '0;
            end
            if (state_q == WAIT && mem_resp_valid) begin
                resp_q <= mem_resp_data;
            end
        end
    end

    assign if_req_ready  = grant[0];
    assign ls_req_ready  = grant[1];

    assign mem_req_valid = (state_q == REQ);
    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;

    assign if_resp_valid = (state_q == RESP) && (owner_q == OWN_IF);
    assign ls_resp_valid = (state_q == RESP) && (owner_q == OWN_LS);
    assign if_resp_data  = if_resp_valid ? resp_q : '0;
    assign ls_resp_data  = ls_resp_valid ? resp_q : '0;

endmodule

// File: tb/tb_ysyx_22041207_mem_arbiter.sv
// tb/tb_ysyx_22041207_mem_arbiter.sv - directed self-checking bench for the memory arbiter
module tb_ysyx_22041207_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid;
    logic [63:0] if_req_addr;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic [63:0] if_resp_data;
    logic        ls_req_valid;
    logic [63:0] ls_req_addr;
    logic        ls_req_wen;
    logic [63:0] ls_req_wdata;
    logic [7:0]  ls_req_wmask;
    logic        ls_req_ready;
    logic        ls_resp_valid;
    logic [63:0] ls_resp_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_22041207_mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_valid   (if_req_valid),
        .if_req_addr    (if_req_addr),
        .if_req_ready   (if_req_ready),
        .if_resp_valid  (if_resp_valid),
        .if_resp_data   (if_resp_data),
        .ls_req_valid   (ls_req_valid),
        .ls_req_addr    (ls_req_addr),
        .ls_req_wen     (ls_req_wen),
        .ls_req_wdata   (ls_req_wdata),
        .ls_req_wmask   (ls_req_wmask),
        .ls_req_ready   (ls_req_ready),
        .ls_resp_valid  (ls_resp_valid),
        .ls_resp_data   (ls_resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_mvalid"}, {63'd0, mem_req_valid}, 64'd0);
        chk({tag, "_ifresp"}, {63'd0, if_resp_valid}, 64'd0);
        chk({tag, "_lsresp"}, {63'd0, ls_resp_valid}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        if_req_valid = 0; if_req_addr = '0;
        ls_req_valid = 0; ls_req_addr = '0; ls_req_wen = 0; ls_req_wdata = '0; ls_req_wmask = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;

        // reset state
        mid();
        chk_quiet("rst");
        chk("rst_ifrdy", {63'd0, if_req_ready}, 64'd0);
        chk("rst_addr", mem_req_addr, 64'd0);
        nxt();
        rst = 1'b0;
        mid();
        chk_quiet("post_rst");
        chk("post_rst_wmask", {56'd0, mem_req_wmask}, 64'd0);

        // IFU read alone; tie-free, last_grant becomes IF
        nxt();
        if_req_valid = 1; if_req_addr = 64'h8000_0000;
        mid();
        chk("if_rdy_T", {63'd0, if_req_ready}, 64'd1);
        chk("if_lsrdy_T", {63'd0, ls_req_ready}, 64'd0);
        chk("if_mvalid_T", {63'd0, mem_req_valid}, 64'd0);
        nxt();
        if_req_valid = 0; if_req_addr = 64'hdead; mem_req_ready = 1;
        mid();
        chk("if_mvalid_T1", {63'd0, mem_req_valid}, 64'd1);
        chk("if_maddr_T1", mem_req_addr, 64'h8000_0000);
        chk("if_mwen_T1", {63'd0, mem_req_wen}, 64'd0);
        chk("if_mwmask_T1", {56'd0, mem_req_wmask}, 64'd0);
        nxt();
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 64'h0000_0413;
        mid();
        chk_quiet("if_T2");
        nxt();
        mem_resp_valid = 0; mem_resp_data = '0;
        mid();
        chk("if_resp_T3", {63'd0, if_resp_valid}, 64'd1);
        chk("if_data_T3", if_resp_data, 64'h0000_0413);
        chk("if_lsresp_T3", {63'd0, ls_resp_valid}, 64'd0);
        nxt();
        mid();
        chk("if_resp_T4", {63'd0, if_resp_valid}, 64'd0);

        // LSU write
        nxt();
        ls_req_valid = 1; ls_req_addr = 64'h8000_1000; ls_req_wen = 1;
        ls_req_wdata = 64'h1122_3344_5566_7788; ls_req_wmask = 8'h0F;
        mid();
        chk("ls_rdy", {63'd0, ls_req_ready}, 64'd1);
        chk("ls_ifrdy", {63'd0, if_req_ready}, 64'd0);
        nxt();
        ls_req_valid = 0; ls_req_wen = 0; ls_req_wdata = '0; ls_req_wmask = '0; mem_req_ready = 1;
        mid();
        chk("ls_mvalid", {63'd0, mem_req_valid}, 64'd1);
        chk("ls_maddr", mem_req_addr, 64'h8000_1000);
        chk("ls_mwen", {63'd0, mem_req_wen}, 64'd1);
        chk("ls_mwdata", mem_req_wdata, 64'h1122_3344_5566_7788);
        chk("ls_mwmask", {56'd0, mem_req_wmask}, 64'h0F);
        nxt();
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 64'hABCD;
        nxt();
        mem_resp_valid = 0; mem_resp_data = '0;
        mid();
        chk("ls_resp", {63'd0, ls_resp_valid}, 64'd1);
        chk("ls_resp_data", ls_resp_data, 64'hABCD);
        chk("ls_ifresp", {63'd0, if_resp_valid}, 64'd0);
        nxt();
        mid();
        chk("ls_resp_once", {63'd0, ls_resp_valid}, 64'd0);

        // backpressure with an early response during REQ
        nxt();
        if_req_valid = 1; if_req_addr = 64'h8000_0040;
        mid();
        chk("bp_ifrdy", {63'd0, if_req_ready}, 64'd1);
        nxt();
        if_req_valid = 0;
        ls_req_valid = 1; ls_req_addr = 64'h8000_9000;
        for (int i = 0; i < 5; i++) begin
            mem_resp_valid = (i == 2);
            mem_resp_data = 64'hBAD;
            mid();
            chk("bp_mvalid", {63'd0, mem_req_valid}, 64'd1);
            chk("bp_maddr", mem_req_addr, 64'h8000_0040);
            chk("bp_ifrdy0", {63'd0, if_req_ready}, 64'd0);
            chk("bp_lsrdy0", {63'd0, ls_req_ready}, 64'd0);
            chk("bp_ifresp0", {63'd0, if_resp_valid}, 64'd0);
            nxt();
        end
        ls_req_valid = 0;
        mem_req_ready = 1; mem_resp_valid = 1; mem_resp_data = 64'hBAD2;
        nxt();
        mem_req_ready = 0; mem_resp_valid = 0;
        mid();
        chk_quiet("early_wait");
        nxt();
        mem_resp_valid = 1; mem_resp_data = 64'h55;
        nxt();
        mem_resp_valid = 0; mem_resp_data = '0;
        mid();
        chk("early_resp", {63'd0, if_resp_valid}, 64'd1);
        chk("early_data", if_resp_data, 64'h55);

        // reset while in WAIT
        nxt();
        nxt();
        if_req_valid = 1; if_req_addr = 64'h8000_0080;
        nxt();
        if_req_valid = 0; mem_req_ready = 1;
        nxt();
        mem_req_ready = 0;
        rst = 1'b1;
        #1;
        chk_quiet("rst_wait");
        nxt();
        mem_resp_valid = 1; mem_resp_data = 64'hBAD3;
        nxt();
        mem_resp_valid = 0;
        rst = 1'b0;
        mid();
        chk_quiet("rst_wait_rel");

        // tie after reset, both held valid: IF, LS, IF, LS
        nxt();
        if_req_valid = 1; if_req_addr = 64'h8000_0100;
        ls_req_valid = 1; ls_req_addr = 64'h8000_2000;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("tie_ifrdy", {63'd0, if_req_ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("tie_lsrdy", {63'd0, ls_req_ready}, (i % 2 == 0) ? 64'd0 : 64'd1);
            nxt();
            mem_req_ready = 1;
            mid();
            chk("tie_maddr", mem_req_addr, (i % 2 == 0) ? 64'h8000_0100 : 64'h8000_2000);
            nxt();
            mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 64'h100 + 64'(i);
            nxt();
            mem_resp_valid = 0;
            mid();
            chk("tie_ifresp", {63'd0, if_resp_valid}, (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("tie_lsresp", {63'd0, ls_resp_valid}, (i % 2 == 0) ? 64'd0 : 64'd1);
            chk("tie_data", (i % 2 == 0) ? if_resp_data : ls_resp_data, 64'h100 + 64'(i));
            nxt();
        end
        if_req_valid = 0; ls_req_valid = 0;
        nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_22041207_mem_arbiter.md
# ysyx_22041207_mem_arbiter

Two-requester memory arbiter between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write with byte mask) and the single shared memory port of the core. It accepts one request at a time from either side and forwards it downstream with a valid/ready handshake. It then routes the single response back to the owner. Tie-breaking is round-robin, so neither side starves. It sits between the IFU/LSU and the memory/DPI bridge, driven by the LSU control the decoder produces: read enable, read size, write mask.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width; write mask width is DATA_W/8
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req_valid  in  1  IFU requests a read
- if_req_addr  in  ADDR_W  IFU address
- if_req_ready  out  1  IFU request accepted this cycle
- if_resp_valid  out  1  one-cycle pulse, if_resp_data valid
- if_resp_data  out  DATA_W  read data
- ls_req_valid  in  1  LSU request
- ls_req_addr  in  ADDR_W  LSU address
- ls_req_wen  in  1  1 = write, 0 = read
- ls_req_wdata  in  DATA_W  write data
- ls_req_wmask  in  DATA_W/8  byte write mask, ignored on reads
- ls_req_ready  out  1  LSU request accepted this cycle
- ls_resp_valid  out  1  one-cycle pulse; for writes it is the completion ack
- ls_resp_data  out  DATA_W  read data; for writes it is the memory's resp data passed through
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accepts the request
- mem_req_addr / mem_req_wen / mem_req_wdata / mem_req_wmask  out  as LSU fields  latched request
- mem_resp_valid  in  1  downstream response, one cycle
- mem_resp_data  in  DATA_W  downstream response data

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. Only one transaction is outstanding at a time.
- **IDLE**
  - If any requester is valid, pick a winner.
  - Assert the winner's req_ready combinationally, in the same cycle.
  - Latch the request fields, set the owner, go to REQ.
  - An IFU request latches wen=0, wmask=0, wdata=0.
- **REQ**
  - mem_req_valid=1, driven from the latched registers only. Requester inputs are ignored.
  - When mem_req_ready=1, go to WAIT.
- **WAIT**
  - When mem_resp_valid=1, latch mem_resp_data and go to RESP.
  - mem_resp_valid in any state other than WAIT is ignored. A response in the same cycle as mem_req_ready is therefore dropped; downstream must respond no earlier than the following cycle.
- **RESP**
  - Pulse the owner's resp_valid for exactly one cycle with the latched data, then go to IDLE.
  - The non-owner's resp_valid stays 0.
- **Arbitration**
  - Only one side valid: that side wins.
  - Both valid: the side not granted last time wins.
  - The last_grant register updates on every grant.
- Requesters must hold valid and fields stable until ready. Responses have no backpressure.
- **Reset**, at any time including mid-transaction:
  - The FSM returns to IDLE and the in-flight transaction is dropped.
  - last_grant resets to LSU, so the first tie goes to the IFU.
  - All latched registers reset to 0.

## Timing
- Every output is 0 during and after reset until a request arrives.
- req_ready is Mealy: high only in IDLE for the selected side.
- Minimum latency, with the request accepted at cycle T:
  - mem_req_valid is high at T+1.
  - With mem_req_ready at T+1 and mem_resp_valid at T+2, resp_valid pulses at T+3.
  - The next request can be accepted at T+4.
- mem_req_valid stays high and its fields stay constant across any number of mem_req_ready=0 cycles.
- WAIT has no timeout; the block waits indefinitely.

## Structure
- Package ysyx_22041207_mem_pkg:
  - state enum {IDLE, REQ, WAIT, RESP}
  - owner enum {OWN_IF, OWN_LS}
  - default ADDR_W/DATA_W localparams
- Sub-module ysyx_22041207_rr_arb2: 2-way round-robin picker.
  - Inputs: two valids, an enable (state==IDLE), clk, rst.
  - Outputs: one-hot grant.
  - Holds the last_grant register internally.
- The top level holds the FSM, request/response latches and output muxing.

## Test plan
- **IFU read alone:** if_req_addr=0x80000000 at T, mem_req_ready=1 at T+1, mem_resp_data=0x00000413 at T+2 -> if_resp_valid pulse at T+3 with 0x00000413; ls_resp_valid stays 0.
- **LSU write:** addr=0x80001000, wdata=0x1122334455667788, wmask=0x0F -> those exact values and mem_req_wen=1 on the mem port; ls_resp_valid pulses once after mem_resp_valid.
- **Tie after reset:** both valid at cycle 0 -> IFU granted first, LSU next. With both held valid continuously, grants alternate IF, LS, IF, LS.
- **Backpressure:** mem_req_ready=0 for 5 cycles -> mem_req_valid high and fields stable for all 5 cycles; both req_ready outputs 0 throughout.
- **Early response:** mem_resp_valid asserted during REQ -> ignored, no resp pulse; the later mem_resp_valid in WAIT is delivered.
- **Reset in WAIT:** rst asserted in WAIT -> mem_req_valid=0 and all resp_valid=0 immediately; after release, a new IFU request completes normally with no stale response.
